// File: rtl/serial_audio_pkg.sv
// Shared types for the serial audio sample path: scheduler FSM states and counter defaults.
package serial_audio_pkg;

    localparam int unsigned UNDERRUN_CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StSendL,
        StSendR
    } sched_state_e;

endpackage

// File: rtl/stereo_sample_scheduler_if.sv
// Handshake bundle between the two mono sources, the scheduler and the encoder sample input.
interface stereo_sample_scheduler_if #(
    parameter int unsigned data_width = 32
);

    logic                  l_valid;
    logic                  l_ready;
    logic [data_width-1:0] l_data;
    logic                  r_valid;
    logic                  r_ready;
    logic [data_width-1:0] r_data;
    logic                  o_valid;
    logic                  o_ready;
    logic                  o_is_left;
    logic [data_width-1:0] o_data;

    // Source/encoder side.
    modport master (
        output l_valid, l_data, r_valid, r_data, o_ready,
        input  l_ready, r_ready, o_valid, o_is_left, o_data
    );

    // Scheduler side.
    modport slave (
        input  l_valid, l_data, r_valid, r_data, o_ready,
        output l_ready, r_ready, o_valid, o_is_left, o_data
    );

endinterface

// File: rtl/sample_holding_reg.sv
// Single-entry sample holding register with full flag; flush wins over load, load over consume.
module sample_holding_reg #(
    parameter int unsigned data_width = 32
) (
    input  logic                  sclk,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic [data_width-1:0] load_data_i,
    input  logic                  consume_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic [data_width-1:0] data_o
);

    logic                  full_q;
    logic [data_width-1:0] data_q;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (flush_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            full_q <= 1'b1;
            data_q <= load_data_i;
        end else if (consume_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/stereo_sample_scheduler.sv
// Left/right alternating sample scheduler with frame-aligned mute and saturating underrun counter.
// Optional build macro SILENCE_FILL_EN: offer zero samples for an empty due channel instead of stalling.
module stereo_sample_scheduler
    import serial_audio_pkg::*;
#(
    parameter int unsigned data_width         = 32,
    parameter int unsigned underrun_cnt_width = UNDERRUN_CNT_W
) (
    input  logic                          sclk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          mute,
    stereo_sample_scheduler_if.slave      bus,
    input  logic                          i_underrun,
    output logic [underrun_cnt_width-1:0] underrun_count,
    output logic                          busy
);

`ifdef SILENCE_FILL_EN
    localparam bit FillEn = 1'b1;
`else
    localparam bit FillEn = 1'b0;
`endif

    localparam logic [underrun_cnt_width-1:0] CntOne = 1;

    sched_state_e state_q, state_d;
    logic         mute_q, mute_d;
    logic         drain_q, drain_d;
    logic         underrun_q;
    logic [underrun_cnt_width-1:0] cnt_q;

    logic                  l_full, r_full;
    logic [data_width-1:0] l_held, r_held;
    logic                  l_ready, r_ready;
    logic                  l_load, r_load;
    logic                  l_consume, r_consume;
    logic                  flush;
    logic                  stop;
    logic                  fill;
    logic                  o_valid;
    logic                  o_is_left;
    logic                  due_full;
    logic [data_width-1:0] due_data;

    // Once draining has begun, a re-asserted enable is ignored until IDLE.
    assign stop = ~enable | drain_q;

    assign l_ready = (state_q != StIdle) & ~l_full;
    assign r_ready = (state_q != StIdle) & ~r_full;
    assign l_load  = bus.l_valid & l_ready;
    assign r_load  = bus.r_valid & r_ready;

    sample_holding_reg #(
        .data_width (data_width)
    ) u_left_reg (
        .sclk        (sclk),
        .reset_n     (reset_n),
        .load_i      (l_load),
        .load_data_i (bus.l_data),
        .consume_i   (l_consume),
        .flush_i     (flush),
        .full_o      (l_full),
        .data_o      (l_held)
    );

    sample_holding_reg #(
        .data_width (data_width)
    ) u_right_reg (
        .sclk        (sclk),
        .reset_n     (reset_n),
        .load_i      (r_load),
        .load_data_i (bus.r_data),
        .consume_i   (r_consume),
        .flush_i     (flush),
        .full_o      (r_full),
        .data_o      (r_held)
    );

    always_comb begin
        state_d   = state_q;
        mute_d    = mute_q;
        l_consume = 1'b0;
        r_consume = 1'b0;
        flush     = 1'b0;
        fill      = 1'b0;
        o_valid   = 1'b0;
        o_is_left = 1'b0;

        unique case (state_q)
            StIdle: begin
                flush = 1'b1;
                if (enable) begin
                    state_d = StPrime;
                end
            end
            StPrime: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (l_full && r_full) begin
                    state_d = StSendL;
                    mute_d  = mute;
                end
            end
            StSendL: begin
                o_is_left = 1'b1;
                fill      = FillEn & ~l_full & bus.o_ready & ~stop;
                o_valid   = l_full | fill;
                if (stop && !l_full) begin
                    state_d = StIdle;
                end else if (o_valid && bus.o_ready) begin
                    l_consume = l_full;
                    // A stopping stream with nothing for the right slot ends here.
                    state_d   = (stop && !r_full) ? StIdle : StSendR;
                end
            end
            StSendR: begin
                fill    = FillEn & ~r_full & bus.o_ready & ~stop;
                o_valid = r_full | fill;
                if (stop && !r_full) begin
                    state_d = StIdle;
                end else if (o_valid && bus.o_ready) begin
                    r_consume = r_full;
                    mute_d    = mute;
                    state_d   = stop ? StIdle : StSendL;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        drain_d = stop & ((state_d == StSendL) | (state_d == StSendR));
    end

    assign due_full = (state_q == StSendL) ? l_full : r_full;
    assign due_data = (state_q == StSendL) ? l_held : r_held;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            mute_q     <= 1'b0;
            drain_q    <= 1'b0;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mute_q     <= mute_d;
            drain_q    <= drain_d;
            underrun_q <= i_underrun;
            if (i_underrun && !underrun_q && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CntOne;
            end
        end
    end

    assign bus.l_ready  = l_ready;
    assign bus.r_ready  = r_ready;
    assign bus.o_valid  = o_valid;
    assign bus.o_is_left = o_is_left;
    // Zero whenever muted or when a silence sample stands in for an empty register.
    assign bus.o_data   = ((state_q == StSendL || state_q == StSendR) && due_full && !mute_q)
                          ? due_data : '0;
    assign underrun_count = cnt_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_stereo_sample_scheduler.sv
// Directed/randomized bench for stereo_sample_scheduler with a queue-based reference model.
module tb_stereo_sample_scheduler;

    logic        sclk;
    logic        reset_n;
    logic        enable;
    logic        mute;
    logic        i_underrun;
    logic [15:0] underrun_count;
    logic        busy;

    logic        sat_underrun;
    logic [5:0]  sat_count;
    logic        sat_busy;

    stereo_sample_scheduler_if #(.data_width(32)) bus ();
    stereo_sample_scheduler_if #(.data_width(32)) sat_bus ();

    stereo_sample_scheduler #(
        .data_width         (32),
        .underrun_cnt_width (16)
    ) dut (
        .sclk           (sclk),
        .reset_n        (reset_n),
        .enable         (enable),
        .mute           (mute),
        .bus            (bus),
        .i_underrun     (i_underrun),
        .underrun_count (underrun_count),
        .busy           (busy)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    stereo_sample_scheduler #(
        .data_width         (32),
        .underrun_cnt_width (6)
    ) u_sat (
        .sclk           (sclk),
        .reset_n        (reset_n),
        .enable         (1'b0),
        .mute           (1'b0),
        .bus            (sat_bus),
        .i_underrun     (sat_underrun),
        .underrun_count (sat_count),
        .busy           (sat_busy)
    );

    assign sat_bus.l_valid = 1'b0;
    assign sat_bus.l_data  = '0;
    assign sat_bus.r_valid = 1'b0;
    assign sat_bus.r_data  = '0;
    assign sat_bus.o_ready = 1'b0;

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: samples waiting at each source, samples transferred but not yet delivered,
    // which channel the encoder should see next, and whether the current frame is muted.
    logic [31:0] src_l[$];
    logic [31:0] src_r[$];
    logic [31:0] exp_l[$];
    logic [31:0] exp_r[$];
    logic        exp_left = 1'b1;
    logic        frame_mute = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sclk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        src_l.push_back(l);
        src_r.push_back(r);
    endtask

    // Source models plus stream-boundary bookkeeping, evaluated on every falling edge.
    initial begin : feeder
        bit fire_l;
        bit fire_r;
        fire_l = 1'b0;
        fire_r = 1'b0;
        bus.l_valid = 1'b0;
        bus.l_data  = '0;
        bus.r_valid = 1'b0;
        bus.r_data  = '0;
        forever begin
            @(negedge sclk);
            if (fire_l && src_l.size() > 0) exp_l.push_back(src_l.pop_front());
            if (fire_r && src_r.size() > 0) exp_r.push_back(src_r.pop_front());
            if (!busy) begin
                exp_l.delete();
                exp_r.delete();
                exp_left   = 1'b1;
                frame_mute = mute;
            end
            bus.l_valid = (src_l.size() > 0);
            bus.l_data  = (src_l.size() > 0) ? src_l[0] : 32'h0;
            bus.r_valid = (src_r.size() > 0);
            bus.r_data  = (src_r.size() > 0) ? src_r[0] : 32'h0;
            fire_l = bus.l_valid && bus.l_ready && reset_n;
            fire_r = bus.r_valid && bus.r_ready && reset_n;
        end
    end

    // Raise o_ready, wait for an offer, check it against the model and let it be accepted.
    task automatic accept_one(input string tag);
        int          n;
        logic        el;
        logic [31:0] exp_data;
        bus.o_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.o_valid && n < 400) begin
            step();
            n++;
        end
        chk({tag, ".valid"}, {31'b0, bus.o_valid}, 32'd1);
        if (bus.o_valid) begin
            el = exp_left;
            chk({tag, ".is_left"}, {31'b0, bus.o_is_left}, {31'b0, el});
            if (el) begin
                chk({tag, ".model_l"}, exp_l.size(), 32'd1);
                exp_data = (exp_l.size() > 0) ? exp_l.pop_front() : 32'h0;
            end else begin
                chk({tag, ".model_r"}, exp_r.size(), 32'd1);
                exp_data = (exp_r.size() > 0) ? exp_r.pop_front() : 32'h0;
            end
            if (frame_mute) exp_data = 32'h0;
            chk({tag, ".data"}, bus.o_data, exp_data);
            if (!el) frame_mute = mute;
            exp_left = ~el;
        end
        step();
        bus.o_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        int exp_und;
        int n;
        reset_n      = 1'b0;
        enable       = 1'b0;
        mute         = 1'b0;
        i_underrun   = 1'b0;
        sat_underrun = 1'b0;
        bus.o_ready  = 1'b0;
        exp_und      = 0;
        repeat (3) step();

        chk("rst.l_ready", {31'b0, bus.l_ready}, 32'd0);
        chk("rst.r_ready", {31'b0, bus.r_ready}, 32'd0);
        chk("rst.o_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("rst.o_is_left", {31'b0, bus.o_is_left}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.o_data", bus.o_data, 32'd0);
        chk("rst.underrun", {16'b0, underrun_count}, 32'd0);
        reset_n = 1'b1;
        step();

        // Basic ordering with a slow encoder.
        push_pair(32'hAAA7AAA3, 32'hAAA80AA4);
        enable = 1'b1;
        repeat (31) step();
        accept_one("t1_l");
        repeat (31) step();
        accept_one("t1_r");

        // Random samples, random encoder gaps.
        for (int i = 0; i < 6; i++) push_pair($urandom, $urandom);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 4)) step();
            accept_one("rand");
        end

        // Mute raised mid-frame only affects the following frame.
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        n = 0;
        while (!(bus.o_valid && bus.o_is_left) && n < 100) begin
            step();
            n++;
        end
        mute = 1'b1;
        repeat (5) step();
        chk("mute.hold_valid", {31'b0, bus.o_valid}, 32'd1);
        chk("mute.hold_data", bus.o_data, (exp_l.size() > 0) ? exp_l[0] : 32'h0);
        accept_one("mute_l0");
        accept_one("mute_r0");
        accept_one("mute_l1");
        mute = 1'b0;
        accept_one("mute_r1");
        chk("mute.dequeued", src_l.size() + src_r.size(), 32'd0);

        // Enable dropped after the left handshake: right still delivered, then idle.
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        accept_one("drain_l");
        enable = 1'b0;
        accept_one("drain_r");
        chk("drain.busy", {31'b0, busy}, 32'd0);
        chk("drain.l_ready", {31'b0, bus.l_ready}, 32'd0);
        chk("drain.r_ready", {31'b0, bus.r_ready}, 32'd0);
        chk("drain.o_valid", {31'b0, bus.o_valid}, 32'd0);
        src_l.delete();
        src_r.delete();

        // Enable bounced while draining: IDLE is still visited once.
        enable = 1'b1;
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        accept_one("bounce_l");
        enable = 1'b0;
        step();
        enable = 1'b1;
        accept_one("bounce_r");
        chk("bounce.idle", {31'b0, busy}, 32'd0);
        step();
        chk("bounce.restart", {31'b0, busy}, 32'd1);
        src_l.push_back($urandom);
        accept_one("bounce_l2");
        accept_one("bounce_r2");

        // Right channel starved after priming.
        src_l.push_back($urandom);
        accept_one("starve_l");
`ifdef SILENCE_FILL_EN
        bus.o_ready = 1'b1;
        #1;
        chk("fill.o_valid", {31'b0, bus.o_valid}, 32'd1);
        chk("fill.is_left", {31'b0, bus.o_is_left}, 32'd0);
        chk("fill.o_data", bus.o_data, 32'd0);
        exp_left   = 1'b1;
        frame_mute = mute;
        step();
        bus.o_ready = 1'b0;
`else
        bus.o_ready = 1'b1;
        repeat (10) step();
        chk("stall.o_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("stall.is_left", {31'b0, bus.o_is_left}, 32'd0);
        chk("stall.busy", {31'b0, busy}, 32'd1);
        bus.o_ready = 1'b0;
`endif
        enable = 1'b0;
        wait_idle("starve_end");

        // Right source late by 100 cycles: nothing offered while priming.
        enable = 1'b1;
        src_l.push_back($urandom);
        repeat (100) step();
        chk("prime.o_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("prime.busy", {31'b0, busy}, 32'd1);
        chk("prime.l_ready", {31'b0, bus.l_ready}, 32'd0);
        chk("prime.r_ready", {31'b0, bus.r_ready}, 32'd1);
        src_r.push_back($urandom);
        accept_one("prime_l");
        accept_one("prime_r");
        enable = 1'b0;
        wait_idle("prime_end");

        // Underrun edges: two short pulses then a long one.
        for (int k = 0; k < 3; k++) begin
            i_underrun = 1'b1;
            exp_und++;
            repeat ((k == 2) ? 50 : 2) step();
            i_underrun = 1'b0;
            repeat (3) step();
            if (k == 0) chk("und.first", {16'b0, underrun_count}, exp_und);
        end
        chk("und.count", {16'b0, underrun_count}, exp_und);

        // Saturation on the narrow instance.
        for (int k = 1; k <= 70; k++) begin
            sat_underrun = 1'b1;
            step();
            sat_underrun = 1'b0;
            step();
            if (k == 40) chk("sat.mid", {26'b0, sat_count}, 32'd40);
        end
        chk("sat.full", {26'b0, sat_count}, (70 > 63) ? 32'd63 : 32'd70);
        chk("sat.idle", {31'b0, sat_busy}, 32'd0);

        // Asynchronous reset while a sample is on offer.
        enable = 1'b1;
        push_pair($urandom, $urandom);
        n = 0;
        while (!bus.o_valid && n < 100) begin
            step();
            n++;
        end
        chk("areset.pre_valid", {31'b0, bus.o_valid}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("areset.o_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("areset.busy", {31'b0, busy}, 32'd0);
        chk("areset.o_is_left", {31'b0, bus.o_is_left}, 32'd0);
        chk("areset.l_ready", {31'b0, bus.l_ready}, 32'd0);
        chk("areset.o_data", bus.o_data, 32'd0);
        chk("areset.underrun", {16'b0, underrun_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
